// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush control slice.
// Holds the sequencer state encoding, the default register-index width and
// the NOP word the inter-stage registers load when flushed or bubbled.
package pipe_ctrl_pkg;

  // Sequencer states: normal issue, or waiting out a multicycle EX op.
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  // Default register-index width (32 architectural registers).
  localparam int REG_ADDR_W_DEF = 5;

  // Instruction word loaded into IF/ID, ID/EX or EX/MEM on flush/bubble.
  // All-zero decodes as a write to register 0, which has no effect.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage : pipe_ctrl_pkg

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator.
// Flags when the load in EX writes a register the ID instruction reads.
// Register 0 is hardwired to zero, so a load targeting it never conflicts.
module load_use_detect #(
  parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rt,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_mem_read,
  output logic                  o_load_use
);

  logic w_rd_nonzero;
  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rd_nonzero = (i_ex_rd != '0);
  assign w_rs_hit     = (i_ex_rd == i_id_rs);
  assign w_rt_hit     = i_id_uses_rt && (i_ex_rd == i_id_rt);

  // Conflict only for a real load into a non-zero register read by ID.
  always_comb begin
    o_load_use = i_ex_mem_read && w_rd_nonzero && (w_rs_hit || w_rt_hit);
  end

endmodule : load_use_detect

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Drives PC / IF/ID / ID/EX enables and the flush/bubble controls from the
// decoded stage fields. Outputs are decoded combinationally from state, the
// multicycle down-counter and the current inputs (zero-latency response).
// Priority in RUN: taken branch > multicycle start > load-use > normal.
// Optional perf counters are built when macro STALL_PERF_EN is defined;
// otherwise stall_cycles / flush_count are tied to zero.
// The current sequencer state is visible on the internal signal w_dbg_state.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mc_start,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_bubble,
  output logic                  busy,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
);

  // Counter value loaded on the start cycle; the start cycle itself is the
  // first of the MC_LATENCY stalled cycles.
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LATENCY - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_nxt_state;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic             w_load_use;
  state_t           w_dbg_state;

  logic w_pc_en;
  logic w_if_id_en;
  logic w_id_ex_en;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_ex_mem_bubble;
  logic w_busy;

  assign w_dbg_state = r_state;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_id_uses_rt  (id_uses_rt),
    .i_ex_rd       (ex_rd),
    .i_ex_mem_read (ex_mem_read),
    .o_load_use    (w_load_use)
  );

  // Mealy decode of controls and next state; reset forces free-running outputs.
  always_comb begin
    w_pc_en         = 1'b1;
    w_if_id_en      = 1'b1;
    w_id_ex_en      = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_ex_mem_bubble = 1'b0;
    w_busy          = 1'b0;
    w_nxt_state     = r_state;
    w_nxt_cnt       = r_cnt;
    if (RST) begin
      w_nxt_state = RUN;
      w_nxt_cnt   = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (ex_branch_taken) begin
            // Wrong-path work in IF and ID is squashed; EX result is kept.
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (ex_mc_start) begin
            w_pc_en         = 1'b0;
            w_if_id_en      = 1'b0;
            w_id_ex_en      = 1'b0;
            w_ex_mem_bubble = 1'b1;
            w_busy          = 1'b1;
            w_nxt_cnt       = MC_LOAD;
            w_nxt_state     = MC_WAIT;
          end else if (w_load_use) begin
            // Hold IF/ID and the PC one cycle; push a bubble into EX.
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
          end
        end
        MC_WAIT: begin
          if (r_cnt != '0) begin
            w_pc_en         = 1'b0;
            w_if_id_en      = 1'b0;
            w_id_ex_en      = 1'b0;
            w_ex_mem_bubble = 1'b1;
            w_busy          = 1'b1;
            w_nxt_cnt       = r_cnt - 1'b1;
          end else begin
            w_nxt_state = RUN;
          end
        end
        default: begin
          w_nxt_state = RUN;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  // State and multicycle down-counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  assign pc_en         = w_pc_en;
  assign if_id_en      = w_if_id_en;
  assign id_ex_en      = w_id_ex_en;
  assign if_id_flush   = w_if_id_flush;
  assign id_ex_flush   = w_id_ex_flush;
  assign ex_mem_bubble = w_ex_mem_bubble;
  assign busy          = w_busy;

`ifdef STALL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // Count stalled-PC cycles and IF/ID flushes; both wrap naturally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!w_pc_en)      r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_if_id_flush) r_flush_count  <= r_flush_count + 32'd1;
    end
  end

  assign stall_cycles = RST ? 32'd0 : r_stall_cycles;
  assign flush_count  = RST ? 32'd0 : r_flush_count;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule : pipe_stall_ctrl

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl. Two instances: MC_LATENCY=4
// (main) and MC_LATENCY=1 (short-op corner). Control vectors are packed
// as {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble, busy}.
module tb_pipe_stall_ctrl;

  localparam logic [6:0] EXP_RUN = 7'b1110000;
  localparam logic [6:0] EXP_LU  = 7'b0010100;
  localparam logic [6:0] EXP_BR  = 7'b1111100;
  localparam logic [6:0] EXP_MC  = 7'b0000011;

  logic       CLK;
  logic       RST;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_branch_taken;
  logic       ex_mc_start;

  logic        pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble, busy;
  logic [31:0] stall_cycles, flush_count;
  logic        pc_en_1, if_id_en_1, id_ex_en_1, if_id_flush_1, id_ex_flush_1, ex_mem_bubble_1, busy_1;
  logic [31:0] stall_cycles_1, flush_count_1;

  logic [6:0] obs;
  logic [6:0] obs_1;
  assign obs   = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble, busy};
  assign obs_1 = {pc_en_1, if_id_en_1, id_ex_en_1, if_id_flush_1, id_ex_flush_1, ex_mem_bubble_1, busy_1};

  int tests_run    = 0;
  int tests_failed = 0;

  logic [6:0] exp_q[$];
  logic [6:0] exp1_q[$];

  pipe_stall_ctrl #(.REG_ADDR_W(5), .MC_LATENCY(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_mc_start(ex_mc_start), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
    .busy(busy), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipe_stall_ctrl #(.REG_ADDR_W(5), .MC_LATENCY(1), .CNT_W(3)) dut_l1 (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_mc_start(ex_mc_start), .pc_en(pc_en_1), .if_id_en(if_id_en_1), .id_ex_en(id_ex_en_1),
    .if_id_flush(if_id_flush_1), .id_ex_flush(id_ex_flush_1), .ex_mem_bubble(ex_mem_bubble_1),
    .busy(busy_1), .stall_cycles(stall_cycles_1), .flush_count(flush_count_1)
  );

  // Clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference load-use rule, written from the hazard definition.
  function automatic logic ref_load_use(input logic [4:0] rs, rt, rd, input logic urt, mr);
    return mr && (rd != 5'd0) && ((rd == rs) || (urt && (rd == rt)));
  endfunction

  task automatic apply(input logic rst, input logic [4:0] rs, rt, input logic urt,
                       input logic [4:0] rd, input logic mr, bt, mc);
    @(posedge CLK);
    #1;
    RST = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_rd = rd; ex_mem_read = mr; ex_branch_taken = bt; ex_mc_start = mc;
  endtask

  // Driver: one cycle of stimulus, expected main-instance controls checked mid-cycle.
  task automatic drive(input string tag, input logic rst, input logic [4:0] rs, rt,
                       input logic urt, input logic [4:0] rd, input logic mr, bt, mc,
                       input logic [6:0] exp);
    apply(rst, rs, rt, urt, rd, mr, bt, mc);
    exp_q.push_back(exp);
    @(negedge CLK);
    check_eq(tag, {25'd0, obs}, {25'd0, exp_q.pop_front()});
  endtask

  // Driver for multicycle-only traffic, checking both latency variants.
  task automatic drive2(input string tag, input logic rst, input logic mc,
                        input logic [6:0] exp, input logic [6:0] exp1);
    apply(rst, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, mc);
    exp_q.push_back(exp);
    exp1_q.push_back(exp1);
    @(negedge CLK);
    check_eq({tag, "_l4"}, {25'd0, obs},   {25'd0, exp_q.pop_front()});
    check_eq({tag, "_l1"}, {25'd0, obs_1}, {25'd0, exp1_q.pop_front()});
  endtask

  task automatic mc_only(input string tag, input logic rst, input logic mc, input logic [6:0] exp);
    drive(tag, rst, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, mc, exp);
  endtask

  initial begin
    logic [4:0] rs, rt, rd;
    logic       urt, mr, bt;
    logic [6:0] e;

    RST = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_rd = '0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_mc_start = 1'b0;

    // Reset with ex_mc_start high: reset wins
    drive2("rst0", 1'b1, 1'b1, EXP_RUN, EXP_RUN);
    drive2("rst1", 1'b1, 1'b1, EXP_RUN, EXP_RUN);
    check_eq("rst_stall_cnt", stall_cycles, 32'd0);
    check_eq("rst_flush_cnt", flush_count, 32'd0);

    // First post-reset cycle starts the stall; held start is ignored in MC_WAIT
    drive2("mc_start", 1'b0, 1'b1, EXP_MC, EXP_MC);
    mc_only("mc_hold2", 1'b0, 1'b1, EXP_MC);
    mc_only("mc_hold3", 1'b0, 1'b1, EXP_MC);
    mc_only("mc_hold4", 1'b0, 1'b1, EXP_MC);
    mc_only("mc_release", 1'b0, 1'b0, EXP_RUN);
    mc_only("mc_idle", 1'b0, 1'b0, EXP_RUN);

    // Single-pulse op on both latencies, then back-to-back on the main one
    drive2("l_reset", 1'b1, 1'b0, EXP_RUN, EXP_RUN);
    drive2("l_start", 1'b0, 1'b1, EXP_MC, EXP_MC);
    drive2("l_c2", 1'b0, 1'b0, EXP_MC, EXP_RUN);
    drive2("l_c3", 1'b0, 1'b0, EXP_MC, EXP_RUN);
    drive2("l_c4", 1'b0, 1'b0, EXP_MC, EXP_RUN);
    drive2("l_rel", 1'b0, 1'b1, EXP_RUN, EXP_MC);
    mc_only("b2b_start", 1'b0, 1'b1, EXP_MC);
    mc_only("b2b_c2", 1'b0, 1'b0, EXP_MC);
    mc_only("b2b_c3", 1'b0, 1'b0, EXP_MC);
    mc_only("b2b_c4", 1'b0, 1'b0, EXP_MC);
    mc_only("b2b_rel", 1'b0, 1'b0, EXP_RUN);

    // Load-use patterns
    drive("lu_rs",      1'b0, 5'd5, 5'd9, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, EXP_LU);
    drive("lu_after",   1'b0, 5'd1, 5'd2, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, EXP_RUN);
    drive("lu_rd0",     1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, EXP_RUN);
    drive("lu_rt_nouse",1'b0, 5'd3, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, EXP_RUN);
    drive("lu_rt_use",  1'b0, 5'd3, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, EXP_LU);
    drive("lu_noload",  1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, EXP_RUN);

    // Branch beats multicycle start and load-use; stays in RUN
    drive("br_prio",    1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, EXP_BR);
    drive("br_next",    1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, EXP_RUN);

    // Random RUN-state traffic (no multicycle starts)
    for (int i = 0; i < 24; i++) begin
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      urt = 1'($urandom_range(0, 1));
      mr  = 1'($urandom_range(0, 1));
      bt  = ($urandom_range(0, 3) == 0);
      e   = bt ? EXP_BR : (ref_load_use(rs, rt, rd, urt, mr) ? EXP_LU : EXP_RUN);
      drive("rand", 1'b0, rs, rt, urt, rd, mr, bt, 1'b0, e);
    end

    // Reset during MC_WAIT abandons the op; a fresh op gets the full stall
    mc_only("rm_start", 1'b0, 1'b1, EXP_MC);
    mc_only("rm_wait1", 1'b0, 1'b0, EXP_MC);
    mc_only("rm_rst",   1'b1, 1'b0, EXP_RUN);
    mc_only("rm_after", 1'b0, 1'b0, EXP_RUN);
    mc_only("rm_new1",  1'b0, 1'b1, EXP_MC);
    mc_only("rm_new2",  1'b0, 1'b0, EXP_MC);
    mc_only("rm_new3",  1'b0, 1'b0, EXP_MC);
    mc_only("rm_new4",  1'b0, 1'b0, EXP_MC);
    mc_only("rm_rel",   1'b0, 1'b0, EXP_RUN);

    // Perf traffic: 3 load-use stalls, one 4-cycle op, 2 branches
    mc_only("pf_rst", 1'b1, 1'b0, EXP_RUN);
    for (int i = 0; i < 3; i++)
      drive("pf_lu", 1'b0, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, EXP_LU);
    mc_only("pf_mc1", 1'b0, 1'b1, EXP_MC);
    mc_only("pf_mc2", 1'b0, 1'b0, EXP_MC);
    mc_only("pf_mc3", 1'b0, 1'b0, EXP_MC);
    mc_only("pf_mc4", 1'b0, 1'b0, EXP_MC);
    mc_only("pf_rel", 1'b0, 1'b0, EXP_RUN);
    for (int i = 0; i < 2; i++)
      drive("pf_br", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, EXP_BR);
    mc_only("pf_idle", 1'b0, 1'b0, EXP_RUN);
`ifdef STALL_PERF_EN
    check_eq("perf_stall", stall_cycles, 32'd7);
    check_eq("perf_flush", flush_count, 32'd2);
    force dut.r_stall_cycles = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_cycles;
    drive("wrap_lu", 1'b0, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, EXP_LU);
    mc_only("wrap_idle", 1'b0, 1'b0, EXP_RUN);
    check_eq("perf_wrap", stall_cycles, 32'd0);
    check_eq("perf_flush_hold", flush_count, 32'd2);
    mc_only("pf_rst2", 1'b1, 1'b0, EXP_RUN);
    check_eq("perf_rst_clr", stall_cycles, 32'd0);
`else
    check_eq("perf_off_stall", stall_cycles, 32'd0);
    check_eq("perf_off_flush", flush_count, 32'd0);
`endif

    check_eq("queue_drained", 32'(exp_q.size() + exp1_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_pipe_stall_ctrl
